pass_pipe: RTL and testbench
============================

# pass_pipe

Parametrised multi-channel pass-through pipeline, successor to the single-bit one-cycle `pass` register. Carries `CHANNELS` lanes of `WIDTH` bits through `DEPTH` register stages under a valid/ready handshake. Supports backpressure with bubble collapse, synchronous flush and an occupancy count. Sits between a producer and consumer wherever a fixed, retimable delay with flow control is needed, and serves as the standard e2e flow smoke-test block.

## Interface
- `WIDTH`, default 8: bits per channel, ≥1
- `CHANNELS`, default 2: number of parallel lanes, ≥1
- `DEPTH`, default 3: pipeline stages, ≥1
- `clock` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `in_valid` input 1: producer beat valid
- `in_ready` output 1: block accepts beat this cycle
- `in_data` input CHANNELS*WIDTH: lane k at bits [k*WIDTH +: WIDTH]
- `out_valid` output 1: last stage holds a beat
- `out_ready` input 1: consumer accepts beat
- `out_data` output CHANNELS*WIDTH: last-stage data
- `flush` input 1: synchronous discard of all stored beats
- `occupancy` output $clog2(DEPTH+1): number of valid stages
- `err_inject` input 1: test hook, see Configuration
- `parity_err` output 1: parity mismatch on current output beat
- `parity_err_sticky` output 1: latched parity error

## Operation
- Each stage i in 0..DEPTH-1 holds a valid bit and a data register; stage 0 is input side, stage DEPTH-1 drives `out_*`.
- Advance rule: `adv[DEPTH-1] = valid[DEPTH-1] & out_ready`; `adv[i] = valid[i] & (!valid[i+1] | adv[i+1])`.
- `in_ready = !flush & (!valid[0] | adv[0])`. Accept = `in_valid & in_ready`.
- Stage i+1 loads stage i data only when `adv[i]`; stage 0 loads `in_data` only on accept. Data registers otherwise hold and are not cleared by advance.
- Valid update: `valid[i]` is set by an incoming beat and cleared by `adv[i]` with no incoming beat.
- Bubble collapse: a stalled output does not block upstream stages while empty stages remain ahead of them.
- `flush` clears every valid bit at the next edge and forces `in_ready` low in that cycle. Flush wins over simultaneous accept and output handshake, but a beat with `out_valid & out_ready` in the flush cycle still counts as delivered.
- `occupancy` is the popcount of the valid bits, updated each cycle, in range 0..DEPTH.
- Lanes are independent data; control is shared by all lanes.

## Timing
- Reset values: all valid bits 0, all data registers 0. Outputs: `out_valid=0`, `out_data=0`, `in_ready=1`, `occupancy=0`, `parity_err=0`, `parity_err_sticky=0`.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge; in-flight beats are lost.
- Latency: a beat accepted at edge N appears with `out_valid` after edge N+DEPTH-1, so it is visible DEPTH cycles later as seen by a sampling bench (`out` changes after the DEPTH-th rising edge).
- Throughput: one beat per cycle with `out_ready` held high.
- Full: DEPTH valid stages and `out_ready=0` gives `in_ready=0`. Full with `out_ready=1` gives `in_ready=1`, which allows simultaneous accept and deliver.
- Empty: `out_valid=0`; `out_data` holds its last value.
- Ready path is combinational from `out_ready` to `in_ready` through DEPTH stages; this is acceptable by design.

## Configuration
- `PASS_PIPE_PARITY_EN` defined:
  - one even-parity bit per lane is generated at stage 0 and carried with the data.
  - Accept with `err_inject=1` inverts lane 0's parity bit.
  - `parity_err = out_valid & (any lane mismatch)`, combinational.
  - `parity_err_sticky` sets on any `parity_err` and clears only on `reset`.
- `PASS_PIPE_PARITY_EN` undefined: no parity storage, `err_inject` is ignored, and `parity_err` and `parity_err_sticky` are tied 0.

## Structure
- Package `pass_pkg` holds the default parameter constants, `occ_width(depth)` and `lane_parity` (a function).
- Sub-module `pass_stage`: one stage holding the valid bit and data plus the optional parity vector. Its ports are `clock`, `reset`, `flush`, `load`, `drain`, `d`, `q` and `valid`. `pass_pipe` instantiates DEPTH of them in a generate loop.

## Test plan
- Reset, then `in_valid=1`, `in_data=16'h00A5` for one cycle with `out_ready=1` -> `out_valid=1` and `out_data=16'h00A5` after the 3rd rising edge, `occupancy` going 1,1,1 then 0.
- Stream 1..10 back-to-back with `out_ready=1` -> outputs 1..10 on consecutive cycles, `in_ready` constant 1.
- Hold `out_ready=0` and offer 5 beats -> 3 accepted, `in_ready=0`, `occupancy=3`. Then `out_ready=1` for one cycle -> one beat delivered and one accepted in the same cycle.
- Fill 2 beats then assert `flush` together with `in_valid=1` -> the new beat is not accepted, `occupancy=0` next cycle, no `out_valid`.
- Assert `reset` asynchronously between edges with 3 beats in flight -> `out_valid`, `occupancy` and `out_data` go to 0 before the next edge.
- With `PASS_PIPE_PARITY_EN`, accept `16'h0001` with `err_inject=1` -> `parity_err=1` while that beat is at the output, and `parity_err_sticky` stays 1 until reset.

Source files
------------

// File: rtl/pass_pkg.sv
// Shared constants and helpers for the pass_pipe pipeline.
// Parity support in the pipeline is enabled with the PASS_PIPE_PARITY_EN macro.
package pass_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 3;

    // Lanes are zero-extended to this width before parity; zero bits do not change XOR
    localparam int LANE_MAX = 64;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic logic lane_parity(input logic [LANE_MAX-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/pass_stage.sv
// One pipeline stage: valid bit plus a data register (data may include parity bits).
// Parity width is folded into W by pass_pipe when PASS_PIPE_PARITY_EN is defined.
module pass_stage #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // An incoming beat keeps the stage full even when its old beat leaves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pass_pipe.sv
// Multi-lane valid/ready pass-through pipeline with bubble collapse, flush and occupancy.
// Optional per-lane even parity with error injection under PASS_PIPE_PARITY_EN.
module pass_pipe
    import pass_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    input  logic                         flush,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    input  logic                         err_inject,
    output logic                         parity_err,
    output logic                         parity_err_sticky
);

    localparam int DW = CHANNELS * WIDTH;
`ifdef PASS_PIPE_PARITY_EN
    localparam int PW = CHANNELS;
`else
    localparam int PW = 0;
`endif
    localparam int SW = DW + PW;
    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [SW-1:0]    stage_q [DEPTH];
    logic [SW-1:0]    stage0_d;
    logic [SW-1:0]    out_beat;
    logic             accept;
    logic             full_above;

    // A stage advances when the output takes a beat or any stage ahead of it is empty;
    // this is the unrolled form of the per-stage advance chain.
    always_comb begin
        full_above = 1'b1;
        adv        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i]     = valid[i] & (~full_above | out_ready);
            full_above = full_above & valid[i];
        end
    end

    assign in_ready = ~flush & (~valid[0] | adv[0]);
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [SW-1:0] d_i;
        logic          load_i;

        if (i == 0) begin : g_head
            assign d_i    = stage0_d;
            assign load_i = accept;
        end else begin : g_body
            assign d_i    = stage_q[i-1];
            assign load_i = adv[i-1];
        end

        pass_stage #(.W(SW)) u_stage (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .load  (load_i),
            .drain (adv[i]),
            .d     (d_i),
            .q     (stage_q[i]),
            .valid (valid[i])
        );
    end

    assign out_beat  = stage_q[DEPTH-1];
    assign out_valid = valid[DEPTH-1];
    assign out_data  = out_beat[DW-1:0];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OW'(valid[i]);
        end
    end

`ifdef PASS_PIPE_PARITY_EN
    logic mismatch;

    // Parity bits sit above the data bits; err_inject corrupts lane 0 only
    always_comb begin
        stage0_d         = '0;
        stage0_d[DW-1:0] = in_data;
        for (int k = 0; k < CHANNELS; k++) begin
            stage0_d[DW+k] = lane_parity(LANE_MAX'(in_data[k*WIDTH +: WIDTH]));
        end
        stage0_d[DW] = stage0_d[DW] ^ err_inject;
    end

    always_comb begin
        mismatch = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            mismatch = mismatch |
                       (lane_parity(LANE_MAX'(out_beat[k*WIDTH +: WIDTH])) ^ out_beat[DW+k]);
        end
    end

    assign parity_err = out_valid & mismatch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_err_sticky <= 1'b0;
        end else if (parity_err) begin
            parity_err_sticky <= 1'b1;
        end
    end
`else
    logic unused_inject;

    assign stage0_d          = in_data;
    assign unused_inject     = err_inject;
    assign parity_err        = 1'b0;
    assign parity_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pass_pipe.sv
// Self-checking bench for pass_pipe using a slot-array reference model.
// Parity expectations follow PASS_PIPE_PARITY_EN.
module tb_pass_pipe;
    import pass_pkg::*;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 3;
    localparam int DW       = WIDTH * CHANNELS;
    localparam int OW       = $clog2(DEPTH + 1);
`ifdef PASS_PIPE_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [OW-1:0] occupancy;
    logic          err_inject;
    logic          parity_err;
    logic          parity_err_sticky;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pass_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .flush             (flush),
        .occupancy         (occupancy),
        .err_inject        (err_inject),
        .parity_err        (parity_err),
        .parity_err_sticky (parity_err_sticky)
    );

    // Reference model: DEPTH slots; a beat moves forward whenever the slot ahead frees up
    bit            mv [DEPTH];
    logic [DW-1:0] md [DEPTH];

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endtask

    function automatic bit m_in_ready();
        bit free;
        free = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) free = !mv[i] || free;
        return !flush && free;
    endfunction

    function automatic int m_occ();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
        return n;
    endfunction

    task automatic m_clock();
        bit            mov [DEPTH];
        bit            nv  [DEPTH];
        logic [DW-1:0] nd  [DEPTH];
        bit            free;
        free = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mov[i] = mv[i] && free;
            free   = !mv[i] || free;
        end
        for (int i = 0; i < DEPTH; i++) begin
            nv[i] = mv[i] && !mov[i];
            nd[i] = md[i];
        end
        if (in_valid && !flush && free) begin
            nv[0] = 1'b1;
            nd[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (mov[i-1]) begin
                nv[i] = 1'b1;
                nd[i] = md[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = flush ? 1'b0 : nv[i];
            md[i] = nd[i];
        end
    endtask

    task automatic cycle();
        m_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out: valid=%b data=%h expected 0/0000", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b1 || occupancy !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: in_ready=%b occ=%0d expected 1/0", in_ready, occupancy);
        end
        checks++;
        if (parity_err !== 1'b0 || parity_err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_parity: err=%b sticky=%b expected 0/0", parity_err, parity_err_sticky);
        end
        reset = 1'b0;
        m_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        int exp_occ [4] = '{1, 1, 1, 0};
        bit exp_ov  [4] = '{0, 0, 1, 0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        cycle();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) cycle();
            checks++;
            if (int'(occupancy) != exp_occ[e] || out_valid !== exp_ov[e]) begin
                errors++;
                $display("[TB] FAIL single_edge%0d: occ=%0d valid=%b expected %0d/%b",
                         e + 1, occupancy, out_valid, exp_occ[e], exp_ov[e]);
            end
            if (exp_ov[e]) begin
                checks++;
                if (out_data !== 16'h00A5) begin
                    errors++;
                    $display("[TB] FAIL single_data: got %h expected 00a5", out_data);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] got [$];
        int            first_edge;
        int            last_edge;
        int            ready_drops;
        first_edge  = -1;
        last_edge   = -1;
        ready_drops = 0;
        out_ready   = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            in_valid = (e <= 10);
            in_data  = DW'(e);
            #1;
            if (e <= 10 && in_ready !== 1'b1) ready_drops++;
            cycle();
            if (out_valid === 1'b1) begin
                got.push_back(out_data);
                if (first_edge < 0) first_edge = e;
                last_edge = e;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (ready_drops != 0) begin
            errors++;
            $display("[TB] FAIL stream_ready: in_ready low %0d cycles expected 0", ready_drops);
        end
        checks++;
        if (first_edge != 3 || last_edge != 12 || got.size() != 10) begin
            errors++;
            $display("[TB] FAIL stream_timing: first=%0d last=%0d count=%0d expected 3/12/10",
                     first_edge, last_edge, got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== DW'(k + 1)) begin
                errors++;
                $display("[TB] FAIL stream_beat%0d: got %h expected %h", k, got[k], DW'(k + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] bp [4];
        int            j;
        for (int k = 0; k < 4; k++) bp[k] = {8'(k + 1), 8'($urandom)};
        j         = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = bp[j];
            #1;
            if (in_ready === 1'b1) begin
                cycle();
                j++;
            end else begin
                cycle();
            end
        end
        checks++;
        if (j != 3 || in_ready !== 1'b0 || int'(occupancy) != 3) begin
            errors++;
            $display("[TB] FAIL bp_full: accepted=%0d in_ready=%b occ=%0d expected 3/0/3",
                     j, in_ready, occupancy);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== bp[0]) begin
            errors++;
            $display("[TB] FAIL bp_head: valid=%b data=%h expected 1/%h", out_valid, out_data, bp[0]);
        end
        out_ready = 1'b1;
        in_data   = bp[3];
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: in_ready=%b expected 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (int'(occupancy) != 3) begin
            errors++;
            $display("[TB] FAIL bp_swap_occ: occ=%0d expected 3", occupancy);
        end
        for (int n = 1; n <= 3; n++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== bp[n]) begin
                errors++;
                $display("[TB] FAIL bp_drain%0d: valid=%b data=%h expected 1/%h",
                         n, out_valid, out_data, bp[n]);
            end
            cycle();
        end
        checks++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: occ=%0d valid=%b expected 0/0", occupancy, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_data = DW'($urandom);
            cycle();
        end
        checks++;
        if (int'(occupancy) != 2) begin
            errors++;
            $display("[TB] FAIL flush_fill: occ=%0d expected 2", occupancy);
        end
        flush   = 1'b1;
        in_data = 16'hBEEF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready: in_ready=%b expected 0", in_ready);
        end
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (occupancy !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_empty%0d: occ=%0d valid=%b expected 0/0",
                         c, occupancy, out_valid);
            end
            cycle();
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] beats [3] = '{16'h1111, 16'h2222, 16'h3333};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = beats[c];
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (int'(occupancy) != 3 || out_valid !== 1'b1 || out_data !== 16'h1111) begin
            errors++;
            $display("[TB] FAIL areset_pre: occ=%0d valid=%b data=%h expected 3/1/1111",
                     occupancy, out_valid, out_data);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_now: valid=%b occ=%0d data=%h ready=%b expected 0/0/0000/1",
                     out_valid, occupancy, out_data, in_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_parity();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 16'h0001;
        err_inject = 1'b1;
        cycle();
        in_valid   = 1'b0;
        err_inject = 1'b0;
        cycle();
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_early: err=%b expected 0", parity_err);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || parity_err !== PAR_ON) begin
            errors++;
            $display("[TB] FAIL parity_hit: valid=%b err=%b expected 1/%b", out_valid, parity_err, PAR_ON);
        end
        cycle();
        checks++;
        if (parity_err !== 1'b0 || parity_err_sticky !== PAR_ON) begin
            errors++;
            $display("[TB] FAIL parity_after: err=%b sticky=%b expected 0/%b",
                     parity_err, parity_err_sticky, PAR_ON);
        end
        in_valid = 1'b1;
        in_data  = 16'h0003;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b1 || parity_err !== 1'b0 || parity_err_sticky !== PAR_ON) begin
            errors++;
            $display("[TB] FAIL parity_clean: valid=%b err=%b sticky=%b expected 1/0/%b",
                     out_valid, parity_err, parity_err_sticky, PAR_ON);
        end
        cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (parity_err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_reset: sticky=%b expected 0", parity_err_sticky);
        end
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        int bad_ready, bad_valid, bad_occ, bad_data, bad_par;
        bad_ready = 0;
        bad_valid = 0;
        bad_occ   = 0;
        bad_data  = 0;
        bad_par   = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = DW'($urandom);
            #1;
            if (in_ready !== m_in_ready()) bad_ready++;
            if (out_valid !== mv[DEPTH-1]) bad_valid++;
            if (int'(occupancy) != m_occ()) bad_occ++;
            if (mv[DEPTH-1] && out_data !== md[DEPTH-1]) bad_data++;
            if (parity_err !== 1'b0) bad_par++;
            cycle();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("[TB] FAIL rand_ready: %0d cycles differ from model expected 0", bad_ready);
        end
        checks++;
        if (bad_valid != 0) begin
            errors++;
            $display("[TB] FAIL rand_valid: %0d cycles differ from model expected 0", bad_valid);
        end
        checks++;
        if (bad_occ != 0) begin
            errors++;
            $display("[TB] FAIL rand_occ: %0d cycles differ from model expected 0", bad_occ);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("[TB] FAIL rand_data: %0d cycles differ from model expected 0", bad_data);
        end
        checks++;
        if (bad_par != 0) begin
            errors++;
            $display("[TB] FAIL rand_parity: %0d cycles with parity_err expected 0", bad_par);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        err_inject = 1'b0;
        m_reset();
        #12;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
